lsu_align_unit: RTL and testbench

//  Load/store alignment unit between the MEM stage and a word-wide data memory port.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_align_unit_load_extend.sv | 26 ++
 rtl/lsu_align_unit.sv | 257 +++++++++++++++++++++++++
 tb/tb_lsu_align_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store alignment unit: access ops, size decode, FSM states.
package lsu_pkg;

  localparam logic [2:0] LSU_OP_LB  = 3'd0;
  localparam logic [2:0] LSU_OP_LBU = 3'd1;
  localparam logic [2:0] LSU_OP_LH  = 3'd2;
  localparam logic [2:0] LSU_OP_LHU = 3'd3;
  localparam logic [2:0] LSU_OP_LW  = 3'd4;
  localparam logic [2:0] LSU_OP_LWU = 3'd5;
  localparam logic [2:0] LSU_OP_LD  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_DONE  = 3'd5
  } lsu_state_e;

  // Access size in bytes; doubleword ops collapse to a word on a 32-bit port.
  function automatic logic [3:0] size_of(input logic [2:0] op, input int dw);
    logic [3:0] n;
    case (op[2:1])
      2'b00:   n = 4'd1;
      2'b01:   n = 4'd2;
      2'b10:   n = 4'd4;
      2'b11:   n = (dw == 64) ? 4'd8 : 4'd4;
      default: n = 4'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_align_unit_load_extend.sv
// Sign/zero extension of right-justified load bytes to the full data width.
module load_extend
  import lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] data_i,
  input  logic [2:0]    op_i,
  output logic [DW-1:0] data_o
);

  logic [3:0]    size_s;
  logic [6:0]    nbits_s;
  logic [DW-1:0] mask_s;
  logic [DW-1:0] msb_mask_s;
  logic          fill_s;

  assign size_s  = size_of(op_i, DW);
  assign nbits_s = {size_s, 3'b000};
  assign mask_s  = ~({DW{1'b1}} << nbits_s);
  // Isolates the top bit of the loaded field so its value can be replicated.
  assign msb_mask_s = mask_s ^ (mask_s >> 1);
  assign fill_s     = ~op_i[0] & (|(data_i & msb_mask_s));
  assign data_o     = (data_i & mask_s) | ({DW{fill_s}} & ~mask_s);

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: splits byte-addressed accesses into word-aligned beats
// and merges/extends load data back for the pipeline.
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int DW             = 32,
  parameter int AW             = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_fault,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  localparam int B   = DW / 8;
  localparam int OW  = $clog2(B);
  localparam int BEW = 2 * B;
  localparam int DWW = 2 * DW;

  lsu_state_e     state_q, state_d;
  logic           we_q, we_d;
  logic [2:0]     op_q, op_d;
  logic [AW-1:0]  word_q, word_d;
  logic [OW-1:0]  off_q, off_d;
  logic           split_q, split_d;
  logic [BEW-1:0] be_w_q, be_w_d;
  logic [DWW-1:0] wd_w_q, wd_w_d;
  logic [DWW-1:0] merge_q, merge_d;

  logic           mem_valid_q, mem_valid_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [B-1:0]   mem_be_q, mem_be_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_fault_q, resp_fault_d;
  logic [DW-1:0]  resp_rdata_q, resp_rdata_d;
  logic           req_ready_q, req_ready_d;

  logic [OW-1:0]  req_off_s;
  logic [3:0]     req_size_s;
  logic [4:0]     req_end_s;
  logic           req_split_s;
  logic [AW-1:0]  req_word_s;
  logic [BEW-1:0] req_be_w_s;
  logic [DWW-1:0] req_wd_w_s;
  logic [DW-1:0]  merged_s;
  logic [DW-1:0]  ext_s;
  logic           issue1_s;
  logic           clear_s;

  // Two-word-wide lane view: low half is beat0, high half is beat1.
  assign req_off_s   = req_addr[OW-1:0];
  assign req_size_s  = size_of(req_op, DW);
  assign req_end_s   = 5'(req_off_s) + 5'(req_size_s);
  assign req_split_s = req_end_s > 5'(B);
  assign req_word_s  = {req_addr[AW-1:OW], {OW{1'b0}}};
  assign req_be_w_s  = BEW'((32'd1 << req_size_s) - 32'd1) << req_off_s;
  assign req_wd_w_s  = DWW'(req_wdata) << {req_off_s, 3'b000};

  assign merged_s = DW'(merge_d >> {off_d, 3'b000});

  load_extend #(.DW(DW)) u_load_extend (
    .data_i (merged_s),
    .op_i   (op_d),
    .data_o (ext_s)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    op_d        = op_q;
    word_d      = word_q;
    off_d       = off_q;
    split_d     = split_q;
    be_w_d      = be_w_q;
    wd_w_d      = wd_w_q;
    merge_d     = merge_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    resp_fault_d = 1'b0;
    issue1_s    = 1'b0;
    clear_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          op_d    = req_op;
          word_d  = req_word_s;
          off_d   = req_off_s;
          split_d = req_split_s;
          be_w_d  = req_be_w_s;
          wd_w_d  = req_wd_w_s;
          merge_d = {DWW{1'b0}};
          if (req_split_s && !ALLOW_MISALIGN) begin
            state_d      = ST_DONE;
            resp_fault_d = 1'b1;
          end else begin
            state_d     = ST_REQ0;
            mem_valid_d = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_word_s;
            mem_be_d    = req_be_w_s[B-1:0];
            mem_wdata_d = req_wd_w_s[DW-1:0];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ0: begin
        if (mem_ready) begin
          if (!we_q) begin
            state_d = ST_WAIT0;
            clear_s = 1'b1;
          end else if (split_q) begin
            state_d  = ST_REQ1;
            issue1_s = 1'b1;
          end else begin
            state_d = ST_DONE;
            clear_s = 1'b1;
          end
        end else begin
          state_d = ST_REQ0;
        end
      end
      ST_WAIT0: begin
        if (mem_rvalid) begin
          merge_d[DW-1:0] = mem_rdata;
          if (split_q) begin
            state_d  = ST_REQ1;
            issue1_s = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_WAIT0;
        end
      end
      ST_REQ1: begin
        if (mem_ready) begin
          clear_s = 1'b1;
          state_d = we_q ? ST_DONE : ST_WAIT1;
        end else begin
          state_d = ST_REQ1;
        end
      end
      ST_WAIT1: begin
        if (mem_rvalid) begin
          merge_d[DWW-1:DW] = mem_rdata;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Beat1 always targets the next word; the address add wraps at 2^AW.
    if (issue1_s) begin
      mem_valid_d = 1'b1;
      mem_we_d    = we_q;
      mem_addr_d  = word_q + AW'(B);
      mem_be_d    = be_w_q[BEW-1:B];
      mem_wdata_d = wd_w_q[DWW-1:DW];
    end else if (clear_s) begin
      mem_valid_d = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = {AW{1'b0}};
      mem_be_d    = {B{1'b0}};
      mem_wdata_d = {DW{1'b0}};
    end else begin
      mem_valid_d = mem_valid_d;
    end
  end

  always_comb begin
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_DONE);
    if (resp_valid_d && !resp_fault_d && !we_d) begin
      resp_rdata_d = ext_s;
    end else begin
      resp_rdata_d = {DW{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      op_q         <= 3'd0;
      word_q       <= {AW{1'b0}};
      off_q        <= {OW{1'b0}};
      split_q      <= 1'b0;
      be_w_q       <= {BEW{1'b0}};
      wd_w_q       <= {DWW{1'b0}};
      merge_q      <= {DWW{1'b0}};
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_be_q     <= {B{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= {DW{1'b0}};
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      op_q         <= op_d;
      word_q       <= word_d;
      off_q        <= off_d;
      split_q      <= split_d;
      be_w_q       <= be_w_d;
      wd_w_q       <= wd_w_d;
      merge_q      <= merge_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_align_unit.sv
// Directed bench for lsu_align_unit: a misalign-splitting instance and a faulting instance.
module tb_lsu_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid_nm, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        req_ready, resp_valid, resp_fault, mem_valid, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        req_ready_nm, resp_valid_nm, resp_fault_nm, mem_valid_nm, mem_we_nm;
  logic [31:0] resp_rdata_nm, mem_addr_nm, mem_wdata_nm;
  logic [3:0]  mem_be_nm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_align_unit #(.DW(32), .AW(32), .ALLOW_MISALIGN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_align_unit #(.DW(32), .AW(32), .ALLOW_MISALIGN(1'b0)) u_dut_nm (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_nm), .req_ready(req_ready_nm), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_nm), .resp_rdata(resp_rdata_nm), .resp_fault(resp_fault_nm),
    .mem_valid(mem_valid_nm), .mem_ready(mem_ready), .mem_we(mem_we_nm), .mem_addr(mem_addr_nm),
    .mem_be(mem_be_nm), .mem_wdata(mem_wdata_nm), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle; returns one cycle after the accept edge.
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_valid_nm = 1'b0; req_we = 1'b0;
    req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    step();
    step();
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_mem_valid", mem_valid, 1'b0);
    chk32("rst_mem_be", 32'(mem_be), 32'h0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_resp_rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    step();

    // LB 0x1003, sign-extended top byte
    issue(1'b0, 3'd0, 32'h0000_1003, 32'h0);
    chk1("lb_mem_valid", mem_valid, 1'b1);
    chk32("lb_mem_addr", mem_addr, 32'h0000_1000);
    chk32("lb_mem_be", 32'(mem_be), 32'h8);
    chk1("lb_req_ready_busy", req_ready, 1'b0);
    chk1("lb_mem_we", mem_we, 1'b0);
    step();
    chk1("lb_wait_mem_valid", mem_valid, 1'b0);
    chk1("lb_wait_resp_valid", resp_valid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    step();
    mem_rvalid = 1'b0;
    chk1("lb_resp_valid", resp_valid, 1'b1);
    chk32("lb_resp_rdata", resp_rdata, 32'hFFFF_FF80);
    chk1("lb_resp_fault", resp_fault, 1'b0);
    step();
    chk1("lb_resp_pulse", resp_valid, 1'b0);
    chk1("lb_req_ready_idle", req_ready, 1'b1);

    // LHU 0x2001 with a competing request held while busy
    issue(1'b0, 3'd3, 32'h0000_2001, 32'h0);
    chk32("lhu_mem_be", 32'(mem_be), 32'h6);
    chk32("lhu_mem_addr", mem_addr, 32'h0000_2000);
    req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h0000_9000;
    step();
    chk1("lhu_req_ready_busy", req_ready, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'hAABB_CCDD;
    step();
    mem_rvalid = 1'b0; req_valid = 1'b0;
    chk1("lhu_resp_valid", resp_valid, 1'b1);
    chk32("lhu_resp_rdata", resp_rdata, 32'h0000_BBCC);
    step();
    chk1("lhu_no_extra_beat", mem_valid, 1'b0);
    chk1("lhu_req_ready_idle", req_ready, 1'b1);

    // LW 0x3002, split across two words, beat1 stalled one cycle
    issue(1'b0, 3'd4, 32'h0000_3002, 32'h0);
    chk32("lw_b0_addr", mem_addr, 32'h0000_3000);
    chk32("lw_b0_be", 32'(mem_be), 32'hC);
    step();
    chk1("lw_wait0_mem_valid", mem_valid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    step();
    mem_rvalid = 1'b0;
    chk1("lw_b1_mem_valid", mem_valid, 1'b1);
    chk32("lw_b1_addr", mem_addr, 32'h0000_3004);
    chk32("lw_b1_be", 32'(mem_be), 32'h3);
    mem_ready = 1'b0;
    step();
    chk1("lw_b1_hold_valid", mem_valid, 1'b1);
    chk32("lw_b1_hold_addr", mem_addr, 32'h0000_3004);
    mem_ready = 1'b1;
    step();
    chk1("lw_wait1_mem_valid", mem_valid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5566_7788;
    step();
    mem_rvalid = 1'b0;
    chk1("lw_resp_valid", resp_valid, 1'b1);
    chk32("lw_resp_rdata", resp_rdata, 32'h7788_1122);
    step();

    // SH 0x4003, split store
    issue(1'b1, 3'd2, 32'h0000_4003, 32'h0000_BEEF);
    chk1("sh_b0_we", mem_we, 1'b1);
    chk32("sh_b0_addr", mem_addr, 32'h0000_4000);
    chk32("sh_b0_be", 32'(mem_be), 32'h8);
    chk32("sh_b0_wdata", mem_wdata, 32'hEF00_0000);
    step();
    chk1("sh_b1_mem_valid", mem_valid, 1'b1);
    chk32("sh_b1_addr", mem_addr, 32'h0000_4004);
    chk32("sh_b1_be", 32'(mem_be), 32'h1);
    chk32("sh_b1_wdata", mem_wdata, 32'h0000_00BE);
    step();
    chk1("sh_resp_valid", resp_valid, 1'b1);
    chk32("sh_resp_rdata", resp_rdata, 32'h0);
    chk1("sh_mem_valid_done", mem_valid, 1'b0);
    step();

    // Aligned SW: response two cycles after accept
    issue(1'b1, 3'd4, 32'h0000_6000, 32'hA5A5_0F0F);
    chk32("sw_be", 32'(mem_be), 32'hF);
    chk32("sw_wdata", mem_wdata, 32'hA5A5_0F0F);
    chk1("sw_resp_early", resp_valid, 1'b0);
    step();
    chk1("sw_resp_valid", resp_valid, 1'b1);
    step();

    // SH at the top of the address space wraps beat1 to word 0
    issue(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_1234);
    chk32("wrap_b0_addr", mem_addr, 32'hFFFF_FFFC);
    chk32("wrap_b0_be", 32'(mem_be), 32'h8);
    chk32("wrap_b0_wdata", mem_wdata, 32'h3400_0000);
    step();
    chk32("wrap_b1_addr", mem_addr, 32'h0000_0000);
    chk32("wrap_b1_be", 32'(mem_be), 32'h1);
    chk32("wrap_b1_wdata", mem_wdata, 32'h0000_0012);
    step();
    chk1("wrap_resp_valid", resp_valid, 1'b1);
    step();

    // Misaligned LW on the faulting instance
    req_valid_nm = 1'b1; req_we = 1'b0; req_op = 3'd4; req_addr = 32'h0000_5001;
    step();
    req_valid_nm = 1'b0;
    chk1("nm_resp_valid", resp_valid_nm, 1'b1);
    chk1("nm_resp_fault", resp_fault_nm, 1'b1);
    chk1("nm_mem_valid", mem_valid_nm, 1'b0);
    chk32("nm_resp_rdata", resp_rdata_nm, 32'h0);
    step();
    chk1("nm_resp_pulse", resp_valid_nm, 1'b0);
    chk1("nm_mem_valid_after", mem_valid_nm, 1'b0);
    chk1("nm_req_ready", req_ready_nm, 1'b1);

    // Reset in WAIT0, then stale read data arrives while idle
    issue(1'b0, 3'd4, 32'h0000_7000, 32'h0);
    chk1("rst6_mem_valid", mem_valid, 1'b1);
    step();
    chk1("rst6_wait0", mem_valid, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rst6_req_ready", req_ready, 1'b1);
    chk1("rst6_mem_valid_idle", mem_valid, 1'b0);
    chk1("rst6_resp_valid", resp_valid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_rvalid = 1'b0;
    chk1("stale_resp_valid", resp_valid, 1'b0);
    chk1("stale_req_ready", req_ready, 1'b1);
    chk1("stale_mem_valid", mem_valid, 1'b0);
    issue(1'b0, 3'd4, 32'h0000_7004, 32'h0);
    chk32("post_lw_addr", mem_addr, 32'h0000_7004);
    chk32("post_lw_be", 32'(mem_be), 32'hF);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    chk1("post_lw_resp_valid", resp_valid, 1'b1);
    chk32("post_lw_rdata", resp_rdata, 32'hCAFE_F00D);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
